// File: rtl/fact_mmio_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// register offsets, FSM state encoding and the default operand limit.
package fact_mmio_pkg;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  // 12! is the largest factorial that fits in 32 bits.
  localparam int MAX_N_DEFAULT = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] status_word(input logic done, input logic err);
    return {30'd0, err, done};
  endfunction

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply step per clock, plus the
// RESULT/done/err registers that software observes through fact_mmio.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | no run since reset; waiting for start
//   S_BUSY | multiplying prod by cnt and counting cnt down
//   S_DONE | run finished or rejected; done/err held until next start
module fact_core
  import fact_mmio_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int MAX_N  = MAX_N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       result
);

  localparam logic [31:0] MAX_N_W = 32'(MAX_N);

  state_t            state;
  state_t            state_nxt;
  logic [N_BITS-1:0] cnt;
  logic [31:0]       prod;
  logic              over_max;
  logic              cnt_last;

  assign over_max = 32'(n) > MAX_N_W;
  assign cnt_last = cnt <= N_BITS'(1);
  assign busy     = (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = over_max ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_last) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Start is only honoured outside S_BUSY; a rejected operand completes
  // immediately with a zero result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      prod   <= 32'd1;
      result <= 32'd0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          if (cnt_last) begin
            result <= prod;
            done   <= 1'b1;
          end else begin
            prod <= prod * 32'(cnt);
            cnt  <= cnt - N_BITS'(1);
          end
        end
        default: begin
          if (start) begin
            cnt  <= n;
            prod <= 32'd1;
            done <= over_max;
            err  <= over_max;
            if (over_max) begin
              result <= 32'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fact_mmio.sv
// Bus-facing wrapper for the factorial engine: holds the N operand,
// decodes word-offset writes and muxes read data with zero latency.
module fact_mmio
  import fact_mmio_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int MAX_N  = MAX_N_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        done
);

  logic [N_BITS-1:0] n_reg;
  logic              start;
  logic              busy;
  logic              err;
  logic [31:0]       result;
  logic              unused_wd;

  assign unused_wd = ^wd[31:N_BITS];

  // The engine ignores start while busy, so GO needs no extra gating here.
  assign start = we && (a == FACT_GO) && wd[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_reg <= '0;
    end else if (we && (a == FACT_N) && !busy) begin
      n_reg <= wd[N_BITS-1:0];
    end
  end

  fact_core #(
    .N_BITS(N_BITS),
    .MAX_N (MAX_N)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n_reg),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .result(result)
  );

  always_comb begin
    rd = 32'd0;
    case (a)
      FACT_N:      rd = {{(32-N_BITS){1'b0}}, n_reg};
      FACT_GO:     rd = {31'd0, busy};
      FACT_STATUS: rd = status_word(done, err);
      FACT_RESULT: rd = result;
      default:     rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fact_mmio.sv
// Directed bench for fact_mmio: register access, completion timing and
// results for boundary operands, error handling, busy write-lockout, reset.
module tb_fact_mmio;
  import fact_mmio_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        done;

  int vectors;
  int miscompares;
  int cyc;
  int busy_cnt;

  fact_mmio #(.N_BITS(4), .MAX_N(12)) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One write lasting exactly one rising edge; returns 1 ns after that edge.
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    wd = data;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(tag, rd, exp);
  endtask

  // Counts edges after the GO write until done, and how many of those
  // sampled cycles GO read back as busy.
  task automatic wait_done(input int bound);
    a = FACT_GO;
    #1;
    cyc      = 0;
    busy_cnt = 0;
    while (!done && cyc < bound) begin
      if (rd == 32'd1) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] n, input int exp_cyc,
                     input logic [31:0] exp_res, input logic [31:0] exp_status);
    wr(FACT_N, n);
    wr(FACT_GO, 32'd1);
    wait_done(40);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_cyc);
    rd_chk({tag, "_status"}, FACT_STATUS, exp_status);
    rd_chk({tag, "_result"}, FACT_RESULT, exp_res);
    rd_chk({tag, "_go_idle"}, FACT_GO, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    we  = 1'b0;
    a   = FACT_N;
    wd  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rst_n", FACT_N, 32'd0);
    rd_chk("rst_go", FACT_GO, 32'd0);
    rd_chk("rst_status", FACT_STATUS, 32'd0);
    rd_chk("rst_result", FACT_RESULT, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("n5", 32'd5, 5, 32'h0000_0078, 32'h1);
    run("n0", 32'd0, 1, 32'd1, 32'h1);
    run("n1", 32'd1, 1, 32'd1, 32'h1);
    run("n12", 32'd12, 12, 32'h1C8C_FC00, 32'h1);
    run("n13", 32'd13, 0, 32'd0, 32'h3);
    run("n3_after_err", 32'd3, 3, 32'd6, 32'h1);

    // GO with bit0 clear, and writes to read-only registers, change nothing.
    wr(FACT_GO, 32'hFFFF_FFFE);
    chk("go0_done", {31'd0, done}, 32'd1);
    rd_chk("go0_go", FACT_GO, 32'd0);
    wr(FACT_RESULT, 32'hFFFF_FFFF);
    rd_chk("ro_result", FACT_RESULT, 32'd6);
    wr(FACT_STATUS, 32'h0000_0000);
    rd_chk("ro_status", FACT_STATUS, 32'h1);
    wr(FACT_N, 32'hFFFF_FFF5);
    rd_chk("n_upper_zero", FACT_N, 32'd5);

    // N and GO writes during a run are dropped; two edges are spent on them.
    wr(FACT_N, 32'd7);
    wr(FACT_GO, 32'd1);
    wr(FACT_N, 32'd2);
    wr(FACT_GO, 32'd1);
    rd_chk("busy_n_kept", FACT_N, 32'd7);
    wait_done(40);
    chk("busy_ign_cycles", cyc, 5);
    rd_chk("busy_ign_result", FACT_RESULT, 32'd5040);
    rd_chk("busy_ign_status", FACT_STATUS, 32'h1);

    // Reset in the middle of a run discards it.
    wr(FACT_N, 32'd10);
    wr(FACT_GO, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd_chk("mid_rst_n", FACT_N, 32'd0);
    rd_chk("mid_rst_go", FACT_GO, 32'd0);
    rd_chk("mid_rst_status", FACT_STATUS, 32'd0);
    rd_chk("mid_rst_result", FACT_RESULT, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run("n4_after_rst", 32'd4, 4, 32'd24, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
